// File: rtl/ins_mem_responder.sv
// Instruction-memory responder for the IFU fetch port; optional misalignment fault with IMEM_MISALIGN_CHECK_EN.
// Latency: a request sampled at edge t returns a one-cycle valid pulse WAIT_CYCLES edges later (same cycle when 0).
// Backpressure: busy stays high from acceptance through the response cycle, and whenever a preload write is present.
module ins_mem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter              INIT_FILE   = ""
) (
    input  logic                  imem_clock_in,
    input  logic                  imem_reset_in,
    input  logic [31:0]           imem_addr_in,
    input  logic                  imem_req_in,
    output logic                  imem_busy_out,
    output logic [31:0]           imem_data_out,
    output logic                  imem_valid_out,
    output logic                  imem_err_out,
    input  logic                  imem_load_en_in,
    input  logic [DEPTH_LOG2-1:0] imem_load_addr_in,
    input  logic [31:0]           imem_load_data_in
);
    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_MISALIGN_CHECK_EN
    localparam bit MISALIGN_CHK = 1'b1;
`else
    localparam bit MISALIGN_CHK = 1'b0;
`endif

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("ins_mem_responder: WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        take;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    // With zero wait states the response is captured on the accepting edge,
    // so the decode must see the live address rather than the latched one.
    logic [31:0] fetch_addr;
    logic [29:0] word_off;
    logic        out_of_range;
    logic        misaligned;
    logic        fetch_fault;
    logic [31:0] fetch_data;

    assign fetch_addr   = (state == S_IDLE) ? imem_addr_in : addr_q;
    assign word_off     = 30'((fetch_addr - BASE_ADDR) >> 2);
    assign out_of_range = (word_off[29:DEPTH_LOG2] != '0);
    assign misaligned   = MISALIGN_CHK && (fetch_addr[1:0] != 2'b00);
    assign fetch_fault  = out_of_range || misaligned;
    assign fetch_data   = fetch_fault ? NOP : mem[word_off[DEPTH_LOG2-1:0]];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!imem_load_en_in && imem_req_in) begin
                    take = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge imem_clock_in) begin
        if (imem_reset_in) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            addr_q <= 32'd0;
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                addr_q <= imem_addr_in;
            end
            if (state_nxt == S_RESP) begin
                data_q <= fetch_data;
                err_q  <= fetch_fault;
            end else if (state == S_RESP) begin
                err_q <= 1'b0;
            end
        end
    end

    // The array is deliberately outside the reset domain so preloaded images survive reset.
    always_ff @(posedge imem_clock_in) begin
        if (!imem_reset_in && state == S_IDLE && imem_load_en_in) begin
            mem[imem_load_addr_in] <= imem_load_data_in;
        end
    end

    assign imem_busy_out  = (state != S_IDLE) || imem_load_en_in;
    assign imem_valid_out = (state == S_RESP);
    assign imem_err_out   = err_q;
    assign imem_data_out  = data_q;

endmodule

// File: tb/tb_ins_mem_responder.sv
// Randomized bench for ins_mem_responder: two instances (2 and 0 wait states) against a cycle-count model.
module tb_ins_mem_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        req;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    logic        busy_o  [2];
    logic [31:0] data_o  [2];
    logic        valid_o [2];
    logic        err_o   [2];

    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ins_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) u_a (
        .imem_clock_in(clk), .imem_reset_in(rst), .imem_addr_in(addr), .imem_req_in(req),
        .imem_busy_out(busy_o[0]), .imem_data_out(data_o[0]), .imem_valid_out(valid_o[0]),
        .imem_err_out(err_o[0]), .imem_load_en_in(load_en), .imem_load_addr_in(load_addr),
        .imem_load_data_in(load_data));

    ins_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0100)) u_b (
        .imem_clock_in(clk), .imem_reset_in(rst), .imem_addr_in(addr), .imem_req_in(req),
        .imem_busy_out(busy_o[1]), .imem_data_out(data_o[1]), .imem_valid_out(valid_o[1]),
        .imem_err_out(err_o[1]), .imem_load_en_in(load_en), .imem_load_addr_in(load_addr),
        .imem_load_data_in(load_data));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a fetch accepted at edge s occupies the responder for periods s..s+W,
    // with the response visible in period s+W and the data holding afterwards.
    int          wcyc [2] = '{2, 0};
    logic [31:0] base [2] = '{32'h0000_0000, 32'h0000_0100};
    logic [31:0] ref_mem [2][1024];
    bit          active [2];
    int          last_s [2];
    logic [31:0] pend_data [2];
    logic        pend_err [2];
    logic [31:0] hold [2];
    int          n = 0;
    bit          armed = 1'b0;

    function automatic void fetch_model(input int k, input logic [31:0] a,
                                        output logic [31:0] d, output logic e);
        logic [31:0] off;
        off = a - base[k];
        if (off >= 32'd4096) begin
            d = NOP; e = 1'b1;
`ifdef IMEM_MISALIGN_CHECK_EN
        end else if (a[1:0] != 2'b00) begin
            d = NOP; e = 1'b1;
`endif
        end else begin
            d = ref_mem[k][off[11:2]]; e = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        n++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                active[k] = 1'b0;
                hold[k]   = 32'd0;
                armed     = 1'b1;
            end else begin
                if (!(active[k] && (n - 1) <= last_s[k] + wcyc[k])) begin
                    if (load_en) begin
                        ref_mem[k][load_addr] = load_data;
                    end else if (req) begin
                        active[k] = 1'b1;
                        last_s[k] = n;
                        fetch_model(k, addr, pend_data[k], pend_err[k]);
                    end
                end
                if (active[k] && n == last_s[k] + wcyc[k]) hold[k] = pend_data[k];
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                logic exp_v;
                logic exp_b;
                exp_v = active[k] && (n == last_s[k] + wcyc[k]);
                exp_b = (active[k] && (n <= last_s[k] + wcyc[k])) || load_en;
                chk($sformatf("model_busy%0d", k), 32'(busy_o[k]), 32'(exp_b));
                chk($sformatf("model_valid%0d", k), 32'(valid_o[k]), 32'(exp_v));
                chk($sformatf("model_err%0d", k), 32'(err_o[k]), 32'(exp_v && pend_err[k]));
                chk($sformatf("model_data%0d", k), data_o[k], hold[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int c);
        req = 1'b0; load_en = 1'b0;
        repeat (c) tick();
    endtask

    task automatic fetch_a(input logic [31:0] a);
        req = 1'b1; addr = a;
        tick();
        req = 1'b0;
        tick(); tick();
        @(negedge clk);
    endtask

    int vcount;

    initial begin
        rst = 1'b1; req = 1'b0; load_en = 1'b0; addr = '0; load_addr = '0; load_data = '0;
        tick(); tick();
        @(negedge clk);
        chk("reset_valid", 32'(valid_o[0]), 32'd0);
        chk("reset_err", 32'(err_o[0]), 32'd0);
        chk("reset_data", data_o[0], 32'd0);
        chk("reset_busy", 32'(busy_o[0]), 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 1024; i++) begin
            load_en = 1'b1; load_addr = 10'(i); load_data = $urandom;
            tick();
        end
        load_en = 1'b1; load_addr = 10'd0; load_data = 32'h0050_0093;
        tick();
        idle(2);

        // Basic fetch: busy for three periods, valid in the third.
        req = 1'b1; addr = 32'h0;
        tick();
        req = 1'b0;
        @(negedge clk);
        chk("lat_busy0", 32'(busy_o[0]), 32'd1);
        chk("lat_valid0", 32'(valid_o[0]), 32'd0);
        tick(); @(negedge clk);
        chk("lat_busy1", 32'(busy_o[0]), 32'd1);
        chk("lat_valid1", 32'(valid_o[0]), 32'd0);
        tick(); @(negedge clk);
        chk("lat_busy2", 32'(busy_o[0]), 32'd1);
        chk("lat_valid2", 32'(valid_o[0]), 32'd1);
        chk("lat_data", data_o[0], 32'h0050_0093);
        chk("lat_err", 32'(err_o[0]), 32'd0);
        tick(); @(negedge clk);
        chk("lat_busy3", 32'(busy_o[0]), 32'd0);
        chk("lat_data_hold", data_o[0], 32'h0050_0093);
        idle(3);

        fetch_a(32'h0000_1000);
        chk("oor_data", data_o[0], NOP);
        chk("oor_err", 32'(err_o[0]), 32'd1);
        idle(3);
        fetch_a(32'h0000_0FFC);
        chk("top_word_err", 32'(err_o[0]), 32'd0);
        idle(3);

        // Request held high: one pulse, re-acceptance four periods later.
        req = 1'b1; addr = 32'h0;
        tick();
        vcount = 0;
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            if (p < 4) vcount += int'(valid_o[0]);
            if (p == 3) chk("held_idle_gap", 32'(busy_o[0]), 32'd0);
            if (p == 4) chk("held_reaccept", 32'(busy_o[0]), 32'd1);
            if (p == 5) req = 1'b0;
            tick();
        end
        chk("held_one_pulse", 32'(vcount), 32'd1);
        idle(4);

        // Reset during WAIT aborts the fetch.
        req = 1'b1; addr = 32'h0;
        tick();
        req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy_o[0]), 32'd0);
        chk("abort_data", data_o[0], 32'd0);
        vcount = 0;
        for (int p = 0; p < 4; p++) begin
            tick(); @(negedge clk);
            vcount += int'(valid_o[0]);
        end
        chk("abort_no_valid", 32'(vcount), 32'd0);
        idle(2);

        // Load wins over a simultaneous request.
        load_en = 1'b1; load_addr = 10'd0; load_data = 32'hDEAD_BEEF; req = 1'b1; addr = 32'h0;
        tick();
        load_en = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("load_blocks_req", 32'(busy_o[0]), 32'd0);
        tick();
        fetch_a(32'h0);
        chk("load_then_fetch", data_o[0], 32'hDEAD_BEEF);
        idle(3);

        fetch_a(32'h0000_0002);
`ifdef IMEM_MISALIGN_CHECK_EN
        chk("misalign_data", data_o[0], NOP);
        chk("misalign_err", 32'(err_o[0]), 32'd1);
`else
        chk("misalign_data", data_o[0], 32'hDEAD_BEEF);
        chk("misalign_err", 32'(err_o[0]), 32'd0);
`endif
        idle(3);

        // Zero wait states: back-to-back requests pulse every other period.
        req = 1'b1; addr = 32'h0000_0100;
        tick();
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            chk($sformatf("w0_valid_p%0d", p), 32'(valid_o[1]), 32'((p % 2) == 0));
            if (p == 0) chk("w0_data", data_o[1], 32'hDEAD_BEEF);
            tick();
        end
        idle(4);

        for (int c = 0; c < 3000; c++) begin
            int pick;
            rst       = ($urandom_range(0, 199) == 0);
            load_en   = ($urandom_range(0, 7) == 0);
            load_addr = 10'($urandom);
            load_data = $urandom;
            req       = 1'($urandom_range(0, 1));
            pick      = int'($urandom_range(0, 7));
            case (pick)
                0, 1:    addr = {20'd0, 10'($urandom), 2'b00};
                2, 3:    addr = 32'h100 + {20'd0, 10'($urandom), 2'b00};
                4:       addr = {20'd0, 12'($urandom)} + 32'h80;
                5:       addr = $urandom;
                6:       addr = 32'h100 - 32'd4;
                default: addr = 32'h1000 + {28'd0, 4'($urandom)};
            endcase
            tick();
        end
        rst = 1'b0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
